// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared state encoding and header packing for the frame stream arbiter
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam int HDR_ID_W  = 2;
  localparam int HDR_SEQ_W = 6;

  function automatic logic [7:0] pack_header(input logic [HDR_ID_W-1:0]  id,
                                             input logic [HDR_SEQ_W-1:0] seq);
    return {id, seq};
  endfunction

endpackage

// File: rtl/frame_stream_arbiter_rr_pick.sv
// rtl/frame_stream_arbiter_rr_pick.sv - combinational round-robin picker, first requester after the last owner
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_last,
  output logic [N-1:0] o_gnt,
  output logic         o_any
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_V = N[IW:0];

  logic [IW-1:0] w_last_idx;
  logic [IW:0]   w_shift;
  logic [IW:0]   w_unshift;
  logic [N-1:0]  w_rot_req;
  logic [N-1:0]  w_rot_gnt;

  always_comb begin
    w_last_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_last[i]) w_last_idx = IW'(i);
    end
  end

  // Rotate so the slot after the last owner sits at bit 0, take the lowest request, rotate back.
  assign w_shift   = {1'b0, w_last_idx} + 1'b1;
  assign w_unshift = N_V - w_shift;
  assign w_rot_req = N'({i_req, i_req} >> w_shift);
  assign w_rot_gnt = w_rot_req & (~w_rot_req + 1'b1);
  assign o_gnt     = N'({w_rot_gnt, w_rot_gnt} >> w_unshift);
  assign o_any     = |i_req;

endmodule

// File: rtl/frame_stream_arbiter.sv
// rtl/frame_stream_arbiter.sv - merges N_SRC framed byte streams into one FIFO port with per-frame headers
module frame_stream_arbiter
  import frame_pkg::*;
#(
  parameter int N_SRC     = 2,
  parameter int MAX_FRAME = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_SRC-1:0]   rx_src_TVALID,
  output logic [N_SRC-1:0]   rx_src_TREADY,
  input  logic [8*N_SRC-1:0] rx_src_TDATA,
  input  logic [N_SRC-1:0]   rx_src_TLAST,
  output logic               tx_fifo_TVALID,
  input  logic               tx_fifo_TREADY,
  output logic [7:0]         tx_fifo_TDATA,
  output logic               tx_fifo_TLAST,
  output logic [N_SRC-1:0]   o_grant,
  output logic               o_trunc
);
  localparam int CW = $clog2(MAX_FRAME);
  localparam logic [N_SRC-1:0] LAST_INIT = {1'b1, {(N_SRC-1){1'b0}}};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_SRC-1:0]     r_grant;
  logic [N_SRC-1:0]     r_last_grant;
  logic [HDR_SEQ_W-1:0] r_seq [N_SRC];
  logic [CW-1:0]        r_byte_cnt;

  logic [N_SRC-1:0]     w_pick;
  logic                 w_any;
  logic                 w_src_valid;
  logic                 w_src_last;
  logic [7:0]           w_src_data;
  logic [HDR_SEQ_W-1:0] w_seq_cur;
  logic [HDR_ID_W-1:0]  w_src_id;
  logic                 w_at_max;
  logic                 w_tx_hs;
  logic                 w_src_hs;
  logic                 w_frame_done;

  rr_pick #(.N(N_SRC)) u_rr_pick (
    .i_req  (rx_src_TVALID),
    .i_last (r_last_grant),
    .o_gnt  (w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_src_valid = |(rx_src_TVALID & r_grant);
    w_src_last  = |(rx_src_TLAST & r_grant);
    w_src_data  = '0;
    w_seq_cur   = '0;
    w_src_id    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (r_grant[k]) begin
        w_src_data = rx_src_TDATA[8*k +: 8];
        w_seq_cur  = r_seq[k];
        w_src_id   = HDR_ID_W'(k);
      end
    end
  end

  assign w_at_max     = (r_byte_cnt == CW'(MAX_FRAME-1));
  assign w_tx_hs      = tx_fifo_TVALID && tx_fifo_TREADY;
  assign w_src_hs     = w_src_valid && |(rx_src_TREADY & r_grant);
  assign w_frame_done = ((r_state == ST_DATA) || (r_state == ST_DRAIN)) && w_src_hs && w_src_last;
  assign o_grant      = r_grant;

  always_comb begin
    w_state_nxt    = r_state;
    tx_fifo_TVALID = 1'b0;
    tx_fifo_TDATA  = '0;
    tx_fifo_TLAST  = 1'b0;
    rx_src_TREADY  = '0;
    o_trunc        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        tx_fifo_TVALID = 1'b1;
        tx_fifo_TDATA  = pack_header(w_src_id, w_seq_cur);
        if (tx_fifo_TREADY) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx_fifo_TVALID = w_src_valid;
        tx_fifo_TDATA  = w_src_data;
        tx_fifo_TLAST  = w_src_last || w_at_max;
        rx_src_TREADY  = r_grant & {N_SRC{tx_fifo_TREADY}};
        if (w_src_hs) begin
          if (w_src_last) begin
            w_state_nxt = ST_IDLE;
          end else if (w_at_max) begin
            o_trunc     = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Swallow the tail of an over-long frame without touching the FIFO.
        rx_src_TREADY = r_grant;
        if (w_src_valid && w_src_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_INIT;
      r_byte_cnt   <= '0;
      for (int k = 0; k < N_SRC; k++) r_seq[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
          end
        end
        ST_HEADER: begin
          if (w_tx_hs) r_byte_cnt <= '0;
        end
        ST_DATA: begin
          if (w_src_hs && !w_src_last && !w_at_max) r_byte_cnt <= r_byte_cnt + 1'b1;
        end
        default: ;
      endcase
      if (w_frame_done) begin
        r_grant <= '0;
        for (int k = 0; k < N_SRC; k++) begin
          if (r_grant[k]) r_seq[k] <= r_seq[k] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// tb/tb_frame_stream_arbiter.sv - self-checking bench for frame_stream_arbiter
module tb_frame_stream_arbiter;
  localparam int N_SRC     = 2;
  localparam int MAX_FRAME = 20;
  localparam int NF        = 10;

  logic                 clk;
  logic                 i_reset;
  logic [N_SRC-1:0]     rx_src_TVALID;
  logic [N_SRC-1:0]     rx_src_TREADY;
  logic [8*N_SRC-1:0]   rx_src_TDATA;
  logic [N_SRC-1:0]     rx_src_TLAST;
  logic                 tx_fifo_TVALID;
  logic                 tx_fifo_TREADY;
  logic [7:0]           tx_fifo_TDATA;
  logic                 tx_fifo_TLAST;
  logic [N_SRC-1:0]     o_grant;
  logic                 o_trunc;

  frame_stream_arbiter #(.N_SRC(N_SRC), .MAX_FRAME(MAX_FRAME)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .rx_src_TVALID  (rx_src_TVALID),
    .rx_src_TREADY  (rx_src_TREADY),
    .rx_src_TDATA   (rx_src_TDATA),
    .rx_src_TLAST   (rx_src_TLAST),
    .tx_fifo_TVALID (tx_fifo_TVALID),
    .tx_fifo_TREADY (tx_fifo_TREADY),
    .tx_fifo_TDATA  (tx_fifo_TDATA),
    .tx_fifo_TLAST  (tx_fifo_TLAST),
    .o_grant        (o_grant),
    .o_trunc        (o_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [1:0]  v;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  l;
    logic        chk;
    logic [14:0] exp_out;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] sb [2][0:511];
  int         sl [2][0:15];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] v, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [1:0] l, input logic chk,
                              input logic tv, input logic [7:0] td, input logic tl,
                              input logic [1:0] g, input logic [1:0] rr);
    vec_t r;
    r.rst = rst; r.v = v; r.d0 = d0; r.d1 = d1; r.l = l; r.chk = chk;
    r.exp_out = {tv, td, tl, g, rr, 1'b0};
    return r;
  endfunction

  function automatic logic [14:0] outs();
    return {tx_fifo_TVALID, tx_fifo_TDATA, tx_fifo_TLAST, o_grant, rx_src_TREADY, o_trunc};
  endfunction

  task automatic idle_inputs();
    rx_src_TVALID  = '0;
    rx_src_TDATA   = '0;
    rx_src_TLAST   = '0;
    tx_fifo_TREADY = 1'b1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("reset_outputs_zero", 32'(outs()), 32'h0);
    @(posedge clk); #1;
  endtask

  // Drives one frame of len bytes (first, first+1, ...) on source k and records the FIFO side.
  task automatic run_frame(input int k, input int len, input logic [7:0] first,
                           input bit toggle, output int ntr);
    int         bp;
    bit         prev_stall;
    logic [7:0] prev_d;
    bit         fin;
    bp = 0; prev_stall = 0; prev_d = '0; fin = 0; ntr = 0;
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < 400 && !fin; c++) begin
      rx_src_TVALID = '0;
      rx_src_TDATA  = '0;
      rx_src_TLAST  = '0;
      if (bp < len) begin
        rx_src_TVALID[k]        = 1'b1;
        rx_src_TDATA[8*k +: 8]  = first + 8'(bp);
        rx_src_TLAST[k]         = (bp == len - 1);
      end
      tx_fifo_TREADY = toggle ? c[0] : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        check("stall_hold_valid", 32'(tx_fifo_TVALID), 32'h1);
        check("stall_hold_data", 32'(tx_fifo_TDATA), 32'(prev_d));
      end
      prev_stall = tx_fifo_TVALID && !tx_fifo_TREADY;
      prev_d     = tx_fifo_TDATA;
      if (o_trunc) ntr++;
      if (tx_fifo_TVALID && tx_fifo_TREADY) begin
        got_d.push_back(tx_fifo_TDATA);
        got_l.push_back(tx_fifo_TLAST);
      end
      if (rx_src_TVALID[k] && rx_src_TREADY[k]) bp++;
      if (bp == len) fin = 1;
      @(posedge clk); #1;
    end
    if (!fin) check("frame_timeout", 32'h0, 32'h1);
    idle_inputs();
  endtask

  // Expected FIFO content for a frame: header, then min(len, MAX_FRAME) bytes counting up from first.
  task automatic check_frame(input string name, input logic [7:0] hdr, input int len,
                             input logic [7:0] first);
    int plen;
    plen = (len > MAX_FRAME) ? MAX_FRAME : len;
    check({name, "_size"}, got_d.size(), plen + 1);
    if (got_d.size() > 0) begin
      check({name, "_hdr"}, 32'(got_d[0]), 32'(hdr));
      check({name, "_hdr_tlast"}, 32'(got_l[0]), 32'h0);
    end
    for (int i = 1; i < got_d.size() && i <= plen; i++) begin
      check({name, "_data"}, 32'(got_d[i]), 32'(first + 8'(i - 1)));
      check({name, "_tlast"}, 32'(got_l[i]), 32'(i == plen));
    end
  endtask

  task automatic run_random();
    int         fi[2], bp[2], fbase[2], mi[2], mbase[2];
    logic [5:0] mseq[2];
    bit         in_fr, done;
    int         id, pos, plen, olen, exp_tr, got_tr, off;
    in_fr = 0; done = 0; id = 0; pos = 0; plen = 0; olen = 0; exp_tr = 0; got_tr = 0;
    for (int k = 0; k < 2; k++) begin
      fi[k] = 0; bp[k] = 0; fbase[k] = 0; mi[k] = 0; mbase[k] = 0; mseq[k] = '0;
      off = 0;
      for (int f = 0; f < NF; f++) begin
        sl[k][f] = $urandom_range(1, 26);
        if (sl[k][f] > MAX_FRAME) exp_tr++;
        for (int b = 0; b < sl[k][f]; b++) sb[k][off + b] = 8'($urandom);
        off += sl[k][f];
      end
    end
    for (int c = 0; c < 20000 && !done; c++) begin
      for (int k = 0; k < 2; k++) begin
        rx_src_TVALID[k]       = (fi[k] < NF) && ($urandom_range(3) != 0);
        rx_src_TDATA[8*k +: 8] = sb[k][fbase[k] + bp[k]];
        rx_src_TLAST[k]        = (fi[k] < NF) && (bp[k] == sl[k][fi[k]] - 1);
      end
      tx_fifo_TREADY = ($urandom_range(9) < 7);
      @(negedge clk);
      if (o_trunc) got_tr++;
      if (tx_fifo_TVALID && tx_fifo_TREADY) begin
        if (!in_fr) begin
          id = int'(tx_fifo_TDATA[7:6]);
          check("rnd_hdr_id_range", 32'(id < N_SRC), 32'h1);
          if (id >= N_SRC) id = 0;
          check("rnd_frame_available", 32'(mi[id] < NF), 32'h1);
          check("rnd_hdr_seq", 32'(tx_fifo_TDATA[5:0]), 32'(mseq[id]));
          check("rnd_hdr_grant", 32'(o_grant), 32'(1 << id));
          check("rnd_hdr_tlast", 32'(tx_fifo_TLAST), 32'h0);
          olen  = sl[id][mi[id]];
          plen  = (olen > MAX_FRAME) ? MAX_FRAME : olen;
          pos   = 0;
          in_fr = 1;
        end else begin
          check("rnd_data", 32'(tx_fifo_TDATA), 32'(sb[id][mbase[id] + pos]));
          check("rnd_tlast", 32'(tx_fifo_TLAST), 32'(pos == plen - 1));
          check("rnd_trunc", 32'(o_trunc), 32'((pos == MAX_FRAME - 1) && (olen > MAX_FRAME)));
          pos++;
          if (pos == plen) begin
            in_fr = 0;
            mseq[id]++;
            mbase[id] += olen;
            mi[id]++;
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (rx_src_TVALID[k] && rx_src_TREADY[k]) begin
          if (rx_src_TLAST[k]) begin
            fbase[k] += sl[k][fi[k]];
            fi[k]++;
            bp[k] = 0;
          end else begin
            bp[k]++;
          end
        end
      end
      done = (fi[0] == NF) && (fi[1] == NF) && (mi[0] == NF) && (mi[1] == NF) && !in_fr;
      @(posedge clk); #1;
    end
    check("rnd_completed", 32'(done), 32'h1);
    check("rnd_trunc_count", 32'(got_tr), 32'(exp_tr));
    idle_inputs();
  endtask

  initial begin
    int ntr;
    i_reset = 1'b0;
    idle_inputs();

    // Single frame from src0, then seq0 shows up as 1 on its next header.
    vq.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b01, 8'h11, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b01, 8'h11, 8'h00, 2'b00, 1, 1, 8'h00, 0, 2'b01, 2'b00));
    vq.push_back(mk(0, 2'b01, 8'h11, 8'h00, 2'b00, 1, 1, 8'h11, 0, 2'b01, 2'b01));
    vq.push_back(mk(0, 2'b01, 8'h22, 8'h00, 2'b00, 1, 1, 8'h22, 0, 2'b01, 2'b01));
    vq.push_back(mk(0, 2'b01, 8'h33, 8'h00, 2'b01, 1, 1, 8'h33, 1, 2'b01, 2'b01));
    vq.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b01, 8'h44, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b01, 8'h44, 8'h00, 2'b00, 1, 1, 8'h01, 0, 2'b01, 2'b00));
    // Both sources busy with 2-byte frames: grants alternate 0,1,0,1.
    vq.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 1, 1, 8'h00, 0, 2'b01, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 1, 1, 8'hA0, 0, 2'b01, 2'b01));
    vq.push_back(mk(0, 2'b11, 8'hA1, 8'hB0, 2'b01, 1, 1, 8'hA1, 1, 2'b01, 2'b01));
    vq.push_back(mk(0, 2'b11, 8'hA2, 8'hB0, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA2, 8'hB0, 2'b00, 1, 1, 8'h40, 0, 2'b10, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA2, 8'hB0, 2'b00, 1, 1, 8'hB0, 0, 2'b10, 2'b10));
    vq.push_back(mk(0, 2'b11, 8'hA2, 8'hB1, 2'b10, 1, 1, 8'hB1, 1, 2'b10, 2'b10));
    vq.push_back(mk(0, 2'b11, 8'hA2, 8'hB2, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA2, 8'hB2, 2'b00, 1, 1, 8'h01, 0, 2'b01, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA2, 8'hB2, 2'b00, 1, 1, 8'hA2, 0, 2'b01, 2'b01));
    vq.push_back(mk(0, 2'b11, 8'hA3, 8'hB2, 2'b01, 1, 1, 8'hA3, 1, 2'b01, 2'b01));
    vq.push_back(mk(0, 2'b11, 8'hA4, 8'hB2, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA4, 8'hB2, 2'b00, 1, 1, 8'h41, 0, 2'b10, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'hA4, 8'hB2, 2'b00, 1, 1, 8'hB2, 0, 2'b10, 2'b10));
    vq.push_back(mk(0, 2'b11, 8'hA4, 8'hB3, 2'b10, 1, 1, 8'hB3, 1, 2'b10, 2'b10));
    // Reset after two payload bytes: outputs clear, seq and round-robin pointer restart.
    vq.push_back(mk(0, 2'b01, 8'h60, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b01, 8'h60, 8'h00, 2'b00, 1, 1, 8'h02, 0, 2'b01, 2'b00));
    vq.push_back(mk(0, 2'b01, 8'h60, 8'h00, 2'b00, 1, 1, 8'h60, 0, 2'b01, 2'b01));
    vq.push_back(mk(0, 2'b01, 8'h61, 8'h00, 2'b00, 1, 1, 8'h61, 0, 2'b01, 2'b01));
    vq.push_back(mk(1, 2'b01, 8'h62, 8'h00, 2'b00, 0, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'h60, 8'h70, 2'b00, 1, 0, 8'h00, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 2'b11, 8'h60, 8'h70, 2'b00, 1, 1, 8'h00, 0, 2'b01, 2'b00));
    vq.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 0, 2'b00, 2'b00));

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      i_reset        = vq[i].rst;
      rx_src_TVALID  = vq[i].v;
      rx_src_TDATA   = {vq[i].d1, vq[i].d0};
      rx_src_TLAST   = vq[i].l;
      tx_fifo_TREADY = 1'b1;
      @(negedge clk);
      if (vq[i].chk) check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp_out));
      @(posedge clk); #1;
    end
    i_reset = 1'b0;
    idle_inputs();

    // Over-long frame from src1, then the next src1 header carries seq+1.
    reset_dut();
    run_frame(1, 25, 8'h01, 0, ntr);
    check_frame("trunc25", 8'h40, 25, 8'h01);
    check("trunc25_pulses", 32'(ntr), 32'h1);
    run_frame(1, 2, 8'hA0, 0, ntr);
    check_frame("after_trunc", 8'h41, 2, 8'hA0);

    // Exactly MAX_FRAME payload bytes is a normal frame.
    run_frame(0, MAX_FRAME, 8'h80, 0, ntr);
    check_frame("exact_max", 8'h00, MAX_FRAME, 8'h80);
    check("exact_max_no_trunc", 32'(ntr), 32'h0);

    // Output backpressure toggling every cycle.
    run_frame(0, 5, 8'h50, 1, ntr);
    check_frame("toggle_rdy", 8'h01, 5, 8'h50);

    // Sequence number wraps after 64 frames.
    reset_dut();
    for (int f = 0; f < 65; f++) begin
      run_frame(0, 1, 8'(f), 0, ntr);
      check("wrap_hdr", (got_d.size() > 0) ? 32'(got_d[0]) : 32'hFFFF, 32'({2'b00, 6'(f)}));
    end

    reset_dut();
    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
